tl_ul_master_port: RTL

- Parametrised TileLink-UL master port between the tiny5 load/store path and the memory interconnect.
- Takes core memory requests (read/write, byte/half/word/double, signed/unsigned) and issues Get, PutFullData or PutPartialData beats on channel A.
- Keeps up to 2^SOURCE_WIDTH requests in flight and tracks them by source ID.
- Returns channel-D responses to the core strictly in request order, with lane-extracted and sign/zero-extended read data.

---
 rtl/tl_ul_master_port.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/tl_ul_master_port.sv
// tl_ul_master_port: TileLink-UL master with in-order response retirement over a source-indexed slot table
module tl_ul_master_port #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int SOURCE_WIDTH = 2
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_write_i,
    input  logic [ADDR_WIDTH-1:0]     req_addr_i,
    input  logic [1:0]                req_size_i,
    input  logic                      req_signed_i,
    input  logic [DATA_WIDTH-1:0]     req_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
    output logic                      rsp_error_o,
    output logic                      a_valid_o,
    input  logic                      a_ready_i,
    output logic [2:0]                a_opcode_o,
    output logic [2:0]                a_param_o,
    output logic [1:0]                a_size_o,
    output logic [SOURCE_WIDTH-1:0]   a_source_o,
    output logic [ADDR_WIDTH-1:0]     a_address_o,
    output logic [DATA_WIDTH/8-1:0]   a_mask_o,
    output logic [DATA_WIDTH-1:0]     a_data_o,
    input  logic                      d_valid_i,
    output logic                      d_ready_o,
    input  logic [2:0]                d_opcode_i,
    input  logic [SOURCE_WIDTH-1:0]   d_source_i,
    input  logic [DATA_WIDTH-1:0]     d_data_i,
    input  logic                      d_error_i,
    output logic [SOURCE_WIDTH:0]     outstanding_o,
    output logic                      proto_err_o
);
    localparam int NSLOT = 1 << SOURCE_WIDTH;
    localparam int STRB  = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(STRB);
    localparam int SB_W  = $clog2(DATA_WIDTH);
    localparam int CNT_W = SOURCE_WIDTH + 1;
    localparam logic [1:0] FULL_SIZE     = 2'(OFF_W);
    localparam logic [2:0] A_PUT_FULL    = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] A_GET         = 3'd4;
    localparam logic [2:0] D_ACK         = 3'd0;
    localparam logic [2:0] D_ACK_DATA    = 3'd1;

    logic [NSLOT-1:0]        busy_q, done_q, write_q, signed_q, err_q;
    logic [1:0]              size_q [NSLOT];
    logic [OFF_W-1:0]        off_q  [NSLOT];
    logic [DATA_WIDTH-1:0]   data_q [NSLOT];
    logic [SOURCE_WIDTH-1:0] alloc_q, retire_q;
    logic [CNT_W-1:0]        outstanding_q, outstanding_d;
    logic                    perr_q, perr_d;

    logic                    a_valid_q;
    logic [2:0]              a_opcode_q, a_opcode_d;
    logic [1:0]              a_size_q;
    logic [SOURCE_WIDTH-1:0] a_source_q;
    logic [ADDR_WIDTH-1:0]   a_address_q;
    logic [STRB-1:0]         a_mask_q, a_mask_d;
    logic [DATA_WIDTH-1:0]   a_data_q, a_data_d;

    logic                    misaligned, accept, rsp_fire, d_hit;
    logic [2:0]              d_exp_op;
    logic [1:0]              rsz;
    logic [DATA_WIDTH-1:0]   shifted, keep;
    logic [SB_W-1:0]         sb_idx;

    assign misaligned  = (req_size_i == 2'd1 && req_addr_i[0])
                       | (req_size_i == 2'd2 && |req_addr_i[1:0])
                       | (req_size_i == 2'd3 && ((DATA_WIDTH == 32) || |req_addr_i[2:0]));
    assign req_ready_o = !busy_q[alloc_q] && (!a_valid_q || a_ready_i);
    assign accept      = req_valid_i && req_ready_o;
    assign rsp_valid_o = busy_q[retire_q] && done_q[retire_q];
    assign rsp_error_o = err_q[retire_q];
    assign rsp_fire    = rsp_valid_o && rsp_ready_i;
    assign d_hit       = d_valid_i && busy_q[d_source_i] && !done_q[d_source_i];
    assign d_exp_op    = write_q[d_source_i] ? D_ACK : D_ACK_DATA;
    assign perr_d      = perr_q | (d_valid_i & (!d_hit | (d_opcode_i != d_exp_op)));
    assign outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(rsp_fire);

    assign a_valid_o     = a_valid_q;
    assign a_opcode_o    = a_opcode_q;
    assign a_param_o     = 3'd0;
    assign a_size_o      = a_size_q;
    assign a_source_o    = a_source_q;
    assign a_address_o   = a_address_q;
    assign a_mask_o      = a_mask_q;
    assign a_data_o      = a_data_q;
    assign d_ready_o     = 1'b1;
    assign outstanding_o = outstanding_q;
    assign proto_err_o   = perr_q;

    // Channel-A beat payload: opcode from direction and width, lane mask, store data replicated per lane
    always_comb begin
        a_opcode_d = !req_write_i ? A_GET : (req_size_i == FULL_SIZE) ? A_PUT_FULL : A_PUT_PARTIAL;
        a_mask_d   = STRB'(((32'd1 << (32'd1 << req_size_i)) - 32'd1) << req_addr_i[OFF_W-1:0]);
        a_data_d   = req_size_i == 2'd0 ? {STRB{req_wdata_i[7:0]}}
                   : req_size_i == 2'd1 ? {(STRB/2){req_wdata_i[15:0]}}
                   : req_size_i == 2'd2 ? {(DATA_WIDTH/32){req_wdata_i[31:0]}}
                   : req_wdata_i;
    end

    // Response data: shift the addressed lane down, keep the access width, then sign/zero extend
    always_comb begin
        rsz         = size_q[retire_q];
        shifted     = data_q[retire_q] >> {off_q[retire_q], 3'b000};
        keep        = ~({DATA_WIDTH{1'b1}} << (32'd8 << rsz));
        sb_idx      = SB_W'((32'd8 << rsz) - 32'd1);
        rsp_rdata_o = write_q[retire_q] ? '0
                    : (shifted & keep) | ((signed_q[retire_q] && shifted[sb_idx]) ? ~keep : '0);
    end

    // Slot table: allocate on accept, complete on D beat (or immediately when misaligned), free on retire
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            busy_q   <= '0;
            done_q   <= '0;
            write_q  <= '0;
            signed_q <= '0;
            err_q    <= '0;
            for (int i = 0; i < NSLOT; i++) begin
                size_q[i] <= '0;
                off_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (rsp_fire) begin
                busy_q[retire_q] <= 1'b0;
                done_q[retire_q] <= 1'b0;
            end
            if (d_hit) begin
                done_q[d_source_i] <= 1'b1;
                data_q[d_source_i] <= d_data_i;
                err_q[d_source_i]  <= d_error_i;
            end
            if (accept) begin
                busy_q[alloc_q]   <= 1'b1;
                done_q[alloc_q]   <= misaligned;
                err_q[alloc_q]    <= misaligned;
                write_q[alloc_q]  <= req_write_i;
                signed_q[alloc_q] <= req_signed_i;
                size_q[alloc_q]   <= req_size_i;
                off_q[alloc_q]    <= req_addr_i[OFF_W-1:0];
                data_q[alloc_q]   <= '0;
            end
        end
    end

    // Circular pointers, occupancy counter and the sticky protocol-error flag
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            alloc_q       <= '0;
            retire_q      <= '0;
            outstanding_q <= '0;
            perr_q        <= 1'b0;
        end else begin
            if (accept) alloc_q <= alloc_q + 1'b1;
            if (rsp_fire) retire_q <= retire_q + 1'b1;
            outstanding_q <= outstanding_d;
            perr_q        <= perr_d;
        end
    end

    // Channel-A register: load on an aligned accept, hold until the beat is taken
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            a_valid_q   <= 1'b0;
            a_opcode_q  <= '0;
            a_size_q    <= '0;
            a_source_q  <= '0;
            a_address_q <= '0;
            a_mask_q    <= '0;
            a_data_q    <= '0;
        end else if (accept && !misaligned) begin
            a_valid_q   <= 1'b1;
            a_opcode_q  <= a_opcode_d;
            a_size_q    <= req_size_i;
            a_source_q  <= alloc_q;
            a_address_q <= req_addr_i;
            a_mask_q    <= a_mask_d;
            a_data_q    <= a_data_d;
        end else if (a_ready_i) begin
            a_valid_q   <= 1'b0;
        end
    end
endmodule
